// File: rtl/sort4_seq_ctrl_if.sv
// Handshake and result bundle for the sequential four-entry sorter.
// The master drives start/operands; the slave (sorter) returns busy/done/results.
interface sort4_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a, b, c, d;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ra, rb, rc, rd;
  logic [2:0]       swaps;

  modport master (
    output start, a, b, c, d,
    input  busy, done, ra, rb, rc, rd, swaps
  );

  modport slave (
    input  start, a, b, c, d,
    output busy, done, ra, rb, rc, rd, swaps
  );
endinterface

// File: rtl/sort4_seq_ctrl.sv
// Four-entry bubble sorter sharing one compare-swap unit over a fixed
// six-cycle schedule; results and swap count publish with a done pulse.
module sort4_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input logic             clk,
  input logic             reset,
  sort4_seq_ctrl_if.slave bus
);
  typedef enum logic {IDLE, SORT} state_t;

  state_t                state, state_nx;
  logic [3:0][WIDTH-1:0] data, data_sw, res;
  logic [1:0]            i, j, j1;
  logic [2:0]            cnt, cnt_nx, swaps;
  logic                  busy, done, sw, last;

  // Single comparator on the adjacent pair selected by j.
  always_comb begin
    j1      = j + 2'd1;
    sw      = DESCEND ? (data[j] < data[j1]) : (data[j] > data[j1]);
    data_sw = data;
    if (sw) begin
      data_sw[j]  = data[j1];
      data_sw[j1] = data[j];
    end
    cnt_nx   = cnt + {2'b00, sw};
    last     = (i == 2'd2);
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SORT;
      SORT:    if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      res   <= '0;
      i     <= '0;
      j     <= '0;
      cnt   <= '0;
      swaps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          data[0] <= bus.a;
          data[1] <= bus.b;
          data[2] <= bus.c;
          data[3] <= bus.d;
          i       <= '0;
          j       <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
        end
        SORT: begin
          data <= data_sw;
          cnt  <= cnt_nx;
          // Pass i ends at j == 2-i, giving (0,0..2),(1,0..1),(2,0).
          if (j == 2'd2 - i) begin
            j <= '0;
            i <= i + 2'd1;
          end else begin
            j <= j1;
          end
          if (last) begin
            res   <= data_sw;
            swaps <= cnt_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.ra    = res[0];
  assign bus.rb    = res[1];
  assign bus.rc    = res[2];
  assign bus.rd    = res[3];
  assign bus.swaps = swaps;
endmodule
